// File: rtl/semaforo_ctrl.sv
// Two-way intersection light controller: timed Moore FSM paced by an internal tick
// prescaler, with a latched side-street request and a night flashing mode.
module semaforo_ctrl #(
   parameter int unsigned TICK_DIV     = 50000000,
   parameter int unsigned T_GREEN_MAIN = 10,
   parameter int unsigned T_GREEN_SIDE = 6,
   parameter int unsigned T_YELLOW     = 2,
   parameter int unsigned T_ALLRED     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       side_req,
   input  logic       night,
   output logic [1:0] light_main,
   output logic [1:0] light_side,
   output logic       tick,
   output logic       req_pending
);

   localparam logic [1:0] LRed    = 2'b00;
   localparam logic [1:0] LYellow = 2'b01;
   localparam logic [1:0] LGreen  = 2'b10;
   localparam logic [1:0] LOff    = 2'b11;

   // Spare encodings 8..15 are never produced and fall back to StAllRedA.
   localparam logic [3:0] StAllRedA   = 4'd0;
   localparam logic [3:0] StMainGreen = 4'd1;
   localparam logic [3:0] StMainYel   = 4'd2;
   localparam logic [3:0] StAllRedB   = 4'd3;
   localparam logic [3:0] StSideGreen = 4'd4;
   localparam logic [3:0] StSideYel   = 4'd5;
   localparam logic [3:0] StFlashOn   = 4'd6;
   localparam logic [3:0] StFlashOff  = 4'd7;

   localparam int unsigned DivW = $clog2(TICK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

   localparam int unsigned TMaxG  = (T_GREEN_MAIN > T_GREEN_SIDE) ? T_GREEN_MAIN : T_GREEN_SIDE;
   localparam int unsigned TMaxYR = (T_YELLOW > T_ALLRED) ? T_YELLOW : T_ALLRED;
   localparam int unsigned TMax   = (TMaxG > TMaxYR) ? TMaxG : TMaxYR;
   localparam int unsigned PhW    = (TMax > 1) ? $clog2(TMax) : 1;

   localparam logic [PhW-1:0] PhGreenMain = PhW'(T_GREEN_MAIN - 1);
   localparam logic [PhW-1:0] PhGreenSide = PhW'(T_GREEN_SIDE - 1);
   localparam logic [PhW-1:0] PhYellow    = PhW'(T_YELLOW - 1);
   localparam logic [PhW-1:0] PhAllRed    = PhW'(T_ALLRED - 1);

   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic [PhW-1:0]  phase_cnt_q, phase_cnt_d;
   logic [3:0]      state_q, state_d;
   logic            req_q, req_d;
   logic [1:0]      main_q, main_d;
   logic [1:0]      side_q, side_d;
   logic            state_chg;
   logic            main_sat;
   logic            req_set, req_clr;

   assign tick        = (div_cnt_q == DivLast);
   assign light_main  = main_q;
   assign light_side  = side_q;
   assign req_pending = req_q;

   assign div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);

   always_comb begin
      state_d = state_q;
      case (state_q)
         StAllRedA: begin
            if (tick && phase_cnt_q == PhAllRed) state_d = night ? StFlashOn : StMainGreen;
         end
         StMainGreen: begin
            if (tick && phase_cnt_q == PhGreenMain && (req_q || night)) state_d = StMainYel;
         end
         StMainYel: begin
            if (tick && phase_cnt_q == PhYellow) state_d = StAllRedB;
         end
         StAllRedB: begin
            if (tick && phase_cnt_q == PhAllRed) state_d = night ? StFlashOn : StSideGreen;
         end
         StSideGreen: begin
            if (tick && phase_cnt_q == PhGreenSide) state_d = StSideYel;
         end
         StSideYel: begin
            if (tick && phase_cnt_q == PhYellow) state_d = StAllRedA;
         end
         StFlashOn: begin
            if (tick) state_d = night ? StFlashOff : StAllRedA;
         end
         StFlashOff: begin
            if (tick) state_d = night ? StFlashOn : StAllRedA;
         end
         default: state_d = StAllRedA;
      endcase
   end

   assign state_chg = (state_d != state_q);
   // Main green parks its counter at the minimum so it can hold indefinitely.
   assign main_sat  = (state_q == StMainGreen) && (phase_cnt_q == PhGreenMain);

   always_comb begin
      phase_cnt_d = phase_cnt_q;
      if (state_chg) begin
         phase_cnt_d = '0;
      end else if (tick && !main_sat) begin
         phase_cnt_d = phase_cnt_q + PhW'(1);
      end
   end

   assign req_set = side_req && (state_q != StSideGreen);
   assign req_clr = state_chg && (state_d == StSideGreen || state_d == StFlashOn);

   always_comb begin
      req_d = req_q;
      if (req_clr) begin
         req_d = 1'b0;
      end else if (req_set) begin
         req_d = 1'b1;
      end
   end

   // Lights are registered from the next state so they track state_q exactly.
   always_comb begin
      main_d = LRed;
      side_d = LRed;
      case (state_d)
         StMainGreen: main_d = LGreen;
         StMainYel:   main_d = LYellow;
         StSideGreen: side_d = LGreen;
         StSideYel:   side_d = LYellow;
         StFlashOn: begin
            main_d = LYellow;
            side_d = LYellow;
         end
         StFlashOff: begin
            main_d = LOff;
            side_d = LOff;
         end
         default: begin
            main_d = LRed;
            side_d = LRed;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q   <= '0;
         phase_cnt_q <= '0;
         state_q     <= StAllRedA;
         req_q       <= 1'b0;
         main_q      <= LRed;
         side_q      <= LRed;
      end else begin
         div_cnt_q   <= div_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         state_q     <= state_d;
         req_q       <= req_d;
         main_q      <= main_d;
         side_q      <= side_d;
      end
   end

   // Only the flashing pairs may show two non-red codes at once.
   a_no_conflict : assert property (@(posedge clk) disable iff (reset)
      !(light_main != LRed && light_side != LRed &&
        !(light_main == light_side && (light_main == LYellow || light_main == LOff))));

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: directed timelines feed a cycle-stamped scoreboard; a monitor
// also checks tick alignment, conflicting pairs and phase lengths every cycle.
module tb_semaforo_ctrl;

   localparam int TDIV = 4;
   localparam int TGM  = 4;
   localparam int TGS  = 3;
   localparam int TY   = 2;
   localparam int TAR  = 1;

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] YEL = 2'b01;
   localparam logic [1:0] GRN = 2'b10;
   localparam logic [1:0] OFF = 2'b11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       side_req = 1'b0;
   logic       night = 1'b0;
   logic [1:0] light_main;
   logic [1:0] light_side;
   logic       tick;
   logic       req_pending;

   semaforo_ctrl #(
      .TICK_DIV    (TDIV),
      .T_GREEN_MAIN(TGM),
      .T_GREEN_SIDE(TGS),
      .T_YELLOW    (TY),
      .T_ALLRED    (TAR)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .side_req   (side_req),
      .night      (night),
      .light_main (light_main),
      .light_side (light_side),
      .tick       (tick),
      .req_pending(req_pending)
   );

   always #5 clk = ~clk;

   // Cycles since the last reset edge; the DUT prescaler equals cyc % TDIV.
   int cyc = 0;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

   typedef struct {
      int         at;
      logic [1:0] lm;
      logic [1:0] ls;
      logic       tk;
      logic       rp;
      bit         ctk;
      bit         crp;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   function automatic void expl(input int cy, input logic [1:0] lm, input logic [1:0] ls,
                                input string name);
      exp_t e;
      e.at = cy; e.lm = lm; e.ls = ls; e.tk = 1'b0; e.rp = 1'b0;
      e.ctk = 1'b0; e.crp = 1'b0; e.name = name;
      sb_q.push_back(e);
   endfunction

   function automatic void expf(input int cy, input logic [1:0] lm, input logic [1:0] ls,
                                input logic tk, input logic rp, input string name);
      exp_t e;
      e.at = cy; e.lm = lm; e.ls = ls; e.tk = tk; e.rp = rp;
      e.ctk = 1'b1; e.crp = 1'b1; e.name = name;
      sb_q.push_back(e);
   endfunction

   function automatic bit seg_len_ok(input logic [1:0] lm, input logic [1:0] ls, input int len);
      if (lm == GRN && ls == RED) return (len >= TGM * TDIV) && (len % TDIV == 0);
      if (lm == YEL && ls == RED) return len == TY * TDIV;
      if (lm == RED && ls == GRN) return len == TGS * TDIV;
      if (lm == RED && ls == YEL) return len == TY * TDIV;
      if (lm == RED && ls == RED) return len == TAR * TDIV;
      if (lm == ls && (lm == YEL || lm == OFF)) return len == TDIV;
      return 1'b0;
   endfunction

   exp_t       mon_e;
   logic [1:0] seg_lm;
   logic [1:0] seg_ls;
   int         seg_len;
   bit         ok;

   initial begin
      seg_lm = RED;
      seg_ls = RED;
      seg_len = 0;
      forever begin
         @(posedge clk);
         #1;
         while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: cycle %0d passed unchecked, now at cycle %0d", mon_e.name,
                     mon_e.at, cyc);
         end
         if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
            mon_e = sb_q.pop_front();
            ok = (light_main === mon_e.lm) && (light_side === mon_e.ls) &&
                 (!mon_e.ctk || tick === mon_e.tk) && (!mon_e.crp || req_pending === mon_e.rp);
            n_tests++;
            if (!ok) begin
               n_fail++;
               $display("FAIL %s @%0d: got main=%b side=%b tick=%b req=%b, want main=%b side=%b tick=%b(chk %0d) req=%b(chk %0d)",
                        mon_e.name, cyc, light_main, light_side, tick, req_pending, mon_e.lm,
                        mon_e.ls, mon_e.tk, mon_e.ctk, mon_e.rp, mon_e.crp);
            end
         end
         n_tests++;
         if (tick !== (cyc % TDIV == TDIV - 1)) begin
            n_fail++;
            $display("FAIL tick_align @%0d: got tick=%b, want %b", cyc, tick,
                     (cyc % TDIV == TDIV - 1));
         end
         n_tests++;
         if (light_main !== RED && light_side !== RED &&
             !(light_main === light_side && (light_main === YEL || light_main === OFF))) begin
            n_fail++;
            $display("FAIL conflict @%0d: got main=%b side=%b, want at least one red", cyc,
                     light_main, light_side);
         end
         if (cyc == 0) begin
            seg_lm = light_main;
            seg_ls = light_side;
            seg_len = 1;
         end else if (light_main === seg_lm && light_side === seg_ls) begin
            seg_len++;
         end else begin
            n_tests++;
            if (!seg_len_ok(seg_lm, seg_ls, seg_len)) begin
               n_fail++;
               $display("FAIL phase_len @%0d: pair %b/%b lasted %0d clk, not a legal length",
                        cyc, seg_lm, seg_ls, seg_len);
            end
            seg_lm = light_main;
            seg_ls = light_side;
            seg_len = 1;
         end
      end
   end

   task automatic wait_cyc(input int k);
      int n = 0;
      while (cyc != k && n < 50000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != k) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_cyc: at cycle %0d, required cycle %0d", cyc, k);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations pending, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Called on a negedge: reset is sampled at the next posedge, which becomes cycle 0.
   task automatic apply_reset();
      drain();
      reset = 1'b1;
      expf(0, RED, RED, 1'b0, 1'b0, "reset_state");
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: no finish, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);

      // Power-up: all-red for one tick, then main green holds with no requests.
      apply_reset();
      expf(3, RED, RED, 1'b1, 1'b0, "s1_first_tick");
      expf(4, GRN, RED, 1'b0, 1'b0, "s1_main_green");
      expf(100, GRN, RED, 1'b0, 1'b0, "s1_hold_100");
      expl(120, GRN, RED, "s1_hold_120");
      wait_cyc(121);

      // Side request after six main-green ticks runs a full side cycle.
      apply_reset();
      expf(28, GRN, RED, 1'b0, 1'b0, "s2_no_req");
      expf(29, GRN, RED, 1'b0, 1'b1, "s2_req_latched");
      expf(31, GRN, RED, 1'b1, 1'b1, "s2_exit_tick");
      expf(32, YEL, RED, 1'b0, 1'b1, "s2_main_yellow");
      expl(39, YEL, RED, "s2_yellow_end");
      expf(40, RED, RED, 1'b0, 1'b1, "s2_allred_b");
      expf(43, RED, RED, 1'b1, 1'b1, "s2_allred_b_tick");
      expf(44, RED, GRN, 1'b0, 1'b0, "s2_side_green_clr");
      expl(55, RED, GRN, "s2_side_green_end");
      expl(56, RED, YEL, "s2_side_yellow");
      expl(63, RED, YEL, "s2_side_yellow_end");
      expf(64, RED, RED, 1'b0, 1'b0, "s2_allred_a");
      expl(67, RED, RED, "s2_allred_a_end");
      expf(68, GRN, RED, 1'b0, 1'b0, "s2_main_again");
      expf(90, GRN, RED, 1'b0, 1'b0, "s2_main_holds");
      wait_cyc(28); side_req = 1'b1;
      wait_cyc(29); side_req = 0;
      wait_cyc(91);

      // Early request keeps the minimum green; night during side green leads to flashing.
      apply_reset();
      expf(7, GRN, RED, 1'b1, 1'b0, "s3_first_green_tick");
      expf(8, GRN, RED, 1'b0, 1'b1, "s3_req_latched");
      expf(19, GRN, RED, 1'b1, 1'b1, "s3_min_green_end");
      expl(20, YEL, RED, "s3_main_yellow");
      expf(28, RED, RED, 1'b0, 1'b1, "s4_allred_b");
      expf(32, RED, GRN, 1'b0, 1'b0, "s4_side_green");
      expl(43, RED, GRN, "s4_side_green_end");
      expl(44, RED, YEL, "s4_side_yellow");
      expl(51, RED, YEL, "s4_side_yellow_end");
      expl(52, RED, RED, "s4_allred_a");
      expf(55, RED, RED, 1'b1, 1'b0, "s4_allred_a_tick");
      expf(56, YEL, YEL, 1'b0, 1'b0, "s4_flash_on");
      expf(58, YEL, YEL, 1'b0, 1'b1, "s4_req_in_flash");
      expf(59, YEL, YEL, 1'b1, 1'b1, "s4_flash_on_tick");
      expf(60, OFF, OFF, 1'b0, 1'b1, "s4_flash_off");
      expf(63, OFF, OFF, 1'b1, 1'b1, "s4_flash_off_tick");
      expf(64, YEL, YEL, 1'b0, 1'b0, "s4_flash_on_clr");
      expl(68, OFF, OFF, "s4_flash_off2");
      expf(71, OFF, OFF, 1'b1, 1'b0, "s4_night_off_tick");
      expl(72, RED, RED, "s4_allred_after_night");
      expl(75, RED, RED, "s4_allred_end");
      expf(76, GRN, RED, 1'b0, 1'b0, "s4_main_green");
      expf(100, GRN, RED, 1'b0, 1'b0, "s4_main_holds");
      wait_cyc(7); side_req = 1'b1;
      wait_cyc(8); side_req = 1'b0;
      wait_cyc(34); night = 1'b1;
      wait_cyc(57); side_req = 1'b1;
      wait_cyc(58); side_req = 1'b0;
      wait_cyc(69); night = 1'b0;
      wait_cyc(101);

      // Clear beats set on side-green entry, held request ignored, reset in side yellow.
      apply_reset();
      expf(6, GRN, RED, 1'b0, 1'b1, "s5_req_latched");
      expf(19, GRN, RED, 1'b1, 1'b1, "s5_green_exit");
      expl(20, YEL, RED, "s5_main_yellow");
      expf(31, RED, RED, 1'b1, 1'b1, "s5_allred_b_tick");
      expf(32, RED, GRN, 1'b0, 1'b0, "s5_clear_wins");
      expf(41, RED, GRN, 1'b0, 1'b0, "s5_held_not_latched");
      expf(44, RED, YEL, 1'b0, 1'b0, "s5_side_yellow");
      expf(46, RED, YEL, 1'b0, 1'b1, "s5_req_in_yellow");
      expf(47, RED, YEL, 1'b1, 1'b1, "s5_before_reset");
      wait_cyc(5); side_req = 1'b1;
      wait_cyc(6); side_req = 1'b0;
      wait_cyc(30); side_req = 1'b1;
      wait_cyc(40); side_req = 1'b0;
      wait_cyc(45); side_req = 1'b1;
      wait_cyc(46); side_req = 1'b0;
      wait_cyc(47);
      apply_reset();
      expf(3, RED, RED, 1'b1, 1'b0, "s5_restart_tick");
      expf(4, GRN, RED, 1'b0, 1'b0, "s5_restart_green");
      expf(24, GRN, RED, 1'b0, 1'b0, "s5_restart_hold");
      wait_cyc(25);

      // Random requests and night toggles; the monitor checks pairs and phase lengths.
      apply_reset();
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         side_req = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 299) == 0) night = ~night;
      end
      side_req = 1'b0;
      night = 1'b0;
      repeat (4) @(negedge clk);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/semaforo_ctrl.md
Name: semaforo_ctrl

Overview:
Two-way intersection controller that generates the 2-bit light codes consumed by the lamp decoder units: one code for the main street, one for the side street. It is a timed Moore FSM driven by an internal tick prescaler. It handles a latched side-street request and a night flashing mode. Its outputs connect directly to the `light` inputs of two lamp decoders.

Parameters:
- TICK_DIV, 50000000, clk cycles per phase tick (1 s at 50 MHz); must be >= 2.
- T_GREEN_MAIN, 10, minimum main-green duration in ticks; must be >= 1.
- T_GREEN_SIDE, 6, side-green duration in ticks; must be >= 1.
- T_YELLOW, 2, yellow duration in ticks; must be >= 1.
- T_ALLRED, 1, all-red clearance duration in ticks; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- side_req  in  1  side-street vehicle/pedestrian request, level or pulse
- night  in  1  request for night flashing mode
- light_main  out  2  main-street light code
- light_side  out  2  side-street light code
- tick  out  1  one-clk pulse per phase tick
- req_pending  out  1  latched side request

Behaviour:
- Light codes: RED=00, YELLOW=01, GREEN=10, OFF=11.
- Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps. tick=1 in exactly the cycle where div_cnt==TICK_DIV-1.
- States and outputs (main/side):
  - ALLRED_A: RED/RED
  - MAIN_GREEN: GREEN/RED
  - MAIN_YELLOW: YELLOW/RED
  - ALLRED_B: RED/RED
  - SIDE_GREEN: RED/GREEN
  - SIDE_YELLOW: RED/YELLOW
  - FLASH_ON: YELLOW/YELLOW
  - FLASH_OFF: OFF/OFF
- Outputs are registered and decoded from the state register only (Moore). A transition evaluated on a tick cycle is visible on the outputs in the following cycle.
- phase_cnt is cleared on every state change and increments on tick. "Phase done" means tick && phase_cnt==T-1 for the current state's duration T.
- Transitions, all taken only on tick cycles:
  - ALLRED_A, phase done (T_ALLRED): go to FLASH_ON if night, else MAIN_GREEN.
  - MAIN_GREEN: once phase_cnt reaches T_GREEN_MAIN-1 it saturates there. Exit to MAIN_YELLOW on a tick with phase_cnt==T_GREEN_MAIN-1 and (req_pending || night). Otherwise main green holds indefinitely.
  - MAIN_YELLOW, phase done (T_YELLOW): go to ALLRED_B.
  - ALLRED_B, phase done (T_ALLRED): go to FLASH_ON if night, else SIDE_GREEN.
  - SIDE_GREEN, phase done (T_GREEN_SIDE): go to SIDE_YELLOW.
  - SIDE_YELLOW, phase done (T_YELLOW): go to ALLRED_A.
  - FLASH_ON / FLASH_OFF: alternate every tick. On a tick with night==0, go to ALLRED_A instead.
- night is never acted on mid-phase. The current green/yellow/all-red phase always completes first.
- req_pending:
  - Set in any cycle where side_req==1 and state!=SIDE_GREEN.
  - Cleared on the cycle SIDE_GREEN is entered.
  - If side_req is held during SIDE_GREEN, it is not latched.
  - Entering FLASH_ON also clears req_pending.
- Simultaneous set and clear in the same cycle: clear wins.
- Reset:
  - state=ALLRED_A, light_main=RED, light_side=RED.
  - div_cnt=0, phase_cnt=0, tick=0, req_pending=0.
  - Asserting reset mid-phase aborts the phase immediately.
- A conflicting pair (both non-RED, other than FLASH_ON/FLASH_OFF) must never be output.
- Unreachable state encodings recover to ALLRED_A on the next clk.

Test Plan:
All scenarios use TICK_DIV=4, T_GREEN_MAIN=4, T_GREEN_SIDE=3, T_YELLOW=2, T_ALLRED=1.
1. Release reset, no requests -> RED/RED for 4 clk, then GREEN/RED (10/00) held for 100+ clk; tick period is exactly 4 clk.
2. Pulse side_req for 1 clk during main green after 6 ticks -> req_pending=1. Then MAIN_YELLOW 2 ticks, ALLRED 1 tick, SIDE_GREEN (00/10) 3 ticks, SIDE_YELLOW 2 ticks, ALLRED, back to GREEN/RED. req_pending clears on SIDE_GREEN entry.
3. side_req pulse at the first main-green tick -> main green still lasts the full 4 ticks (16 clk) before yellow.
4. Assert night during SIDE_GREEN -> side green/yellow complete, then ALLRED_A, then alternating 01/01 and 11/11 each 4 clk. Deassert night -> ALLRED_A, then GREEN/RED.
5. Assert reset during SIDE_YELLOW -> next clk RED/RED, tick=0, req_pending=0; sequence restarts as in scenario 1.
6. Randomised side_req/night for 10k clk -> checker confirms no non-flash cycle has both codes non-00, and every phase length matches its parameter.
